// File: rtl/two_input_k_add_cell_pkg.sv
// rtl/two_input_k_add_cell_pkg.sv - shared helpers for the Kogge-Stone adder cell
package two_input_k_add_cell_pkg;

   // Number of prefix levels needed to span a given width: ceil(log2(width)), 0 for width 1.
   function automatic int ks_levels(input int width);
      int n;
      n = 0;
      while ((1 << n) < width) n++;
      return n;
   endfunction

endpackage

// File: rtl/two_input_k_add_cell_ks_prefix_cell.sv
// rtl/two_input_k_add_cell_ks_prefix_cell.sv - Kogge-Stone generate/propagate combine node
module ks_prefix_cell (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   input  logic p_lo,
   output logic g_out,
   output logic p_out
);

   assign g_out = g_hi | (p_hi & g_lo);
   assign p_out = p_hi & p_lo;

endmodule

// File: rtl/two_input_k_add_cell.sv
// rtl/two_input_k_add_cell.sv - registered modulo-2^WIDTH adder with Kogge-Stone carry tree
module two_input_k_add_cell
   import two_input_k_add_cell_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Sum
);

   localparam int LEVELS = ks_levels(WIDTH);

   // Row 0 holds bitwise generate/propagate; row k+1 is the output of prefix level k.
   logic [LEVELS:0][WIDTH-1:0] g_lvl;
   logic [LEVELS:0][WIDTH-1:0] p_lvl;
   logic [WIDTH-1:0]           carry;
   logic                       unused_prefix;

   assign g_lvl[0] = A & B;
   assign p_lvl[0] = A ^ B;

   for (genvar lv = 0; lv < LEVELS; lv++) begin : g_level
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= (1 << lv)) begin : g_comb
            ks_prefix_cell u_cell (
               .g_hi  (g_lvl[lv][i]),
               .p_hi  (p_lvl[lv][i]),
               .g_lo  (g_lvl[lv][i-(1<<lv)]),
               .p_lo  (p_lvl[lv][i-(1<<lv)]),
               .g_out (g_lvl[lv+1][i]),
               .p_out (p_lvl[lv+1][i])
            );
         end else begin : g_pass
            assign g_lvl[lv+1][i] = g_lvl[lv][i];
            assign p_lvl[lv+1][i] = p_lvl[lv][i];
         end
      end
   end

   // Carry into bit i is the group generate of bits i-1..0; carry-in is zero.
   if (WIDTH > 1) begin : g_carry
      assign carry = {g_lvl[LEVELS][WIDTH-2:0], 1'b0};
   end else begin : g_nocarry
      assign carry = '0;
   end

   // MSB carry-out and final-level group propagates have no consumer.
   assign unused_prefix = ^{g_lvl[LEVELS][WIDTH-1], p_lvl[LEVELS]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Sum <= '0;
      end else begin
         Sum <= p_lvl[0] ^ carry;
      end
   end

endmodule

// File: tb/tb_two_input_k_add_cell.sv
// tb/tb_two_input_k_add_cell.sv - self-checking bench for two_input_k_add_cell at widths 2, 5 and 8
module tb_two_input_k_add_cell;

   logic       clk;
   logic       rst_n;
   logic [1:0] a2, b2, sum2;
   logic [4:0] a5, b5, sum5;
   logic [7:0] a8, b8, sum8;

   int n_checks;
   int n_fail;

   two_input_k_add_cell #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .A(a2), .B(b2), .Sum(sum2));
   two_input_k_add_cell #(.WIDTH(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .A(a5), .B(b5), .Sum(sum5));
   two_input_k_add_cell #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Sum(sum8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer addition reduced modulo 2^w.
   function automatic logic [7:0] ref_sum(input logic [7:0] a, input logic [7:0] b, input int w);
      int m;
      m = 1 << w;
      return 8'(((int'(a) % m) + (int'(b) % m)) % m);
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [7:0] a, input logic [7:0] b);
      check({tag, "/w2"}, {6'b0, sum2}, ref_sum(a, b, 2));
      check({tag, "/w5"}, {3'b0, sum5}, ref_sum(a, b, 5));
      check({tag, "/w8"}, sum8, ref_sum(a, b, 8));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "/w2"}, {6'b0, sum2}, 8'h00);
      check({tag, "/w5"}, {3'b0, sum5}, 8'h00);
      check({tag, "/w8"}, sum8, 8'h00);
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b);
      a2 = a[1:0]; b2 = b[1:0];
      a5 = a[4:0]; b5 = b[4:0];
      a8 = a;      b8 = b;
   endtask

   task automatic apply(input string tag, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      drive(a, b);
      @(posedge clk);
      #1;
      check_all(tag, a, b);
   endtask

   initial begin
      logic [7:0] ra, rb;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b1;
      drive(8'hFF, 8'hFF);

      // Asynchronous reset before any clock edge
      #1 rst_n = 1'b0;
      #1 check_zero("reset_async");
      repeat (3) @(posedge clk);
      #1 check_zero("reset_hold");

      // Release: first edge captures the current A + B
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check_all("reset_release", 8'hFF, 8'hFF);

      apply("basic", 8'h01, 8'h02);
      apply("wrap_a", 8'h02, 8'h03);
      apply("wrap_b", 8'h03, 8'h01);

      // Back-to-back through all 2-bit combinations
      for (int i = 0; i < 16; i++) begin
         apply("all16", 8'(i / 4), 8'(i % 4));
      end

      // Mid-stream reset between edges while Sum = 3
      apply("pre_mid_reset", 8'h01, 8'h02);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check_all("post_mid_reset", 8'h01, 8'h02);

      // Inputs changed between edges must not disturb the registered result
      apply("hold_base", 8'h10, 8'h25);
      @(negedge clk);
      drive(8'hC3, 8'h5A);
      #1 check_all("between_edges", 8'h10, 8'h25);
      @(posedge clk);
      #1 check_all("next_edge", 8'hC3, 8'h5A);

      apply("ff_plus_1", 8'hFF, 8'h01);
      apply("7f_plus_1", 8'h7F, 8'h01);
      apply("zero", 8'h00, 8'h00);
      apply("1f_plus_1", 8'h1F, 8'h01);

      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         apply("random", ra, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
